// File: rtl/seq_mult_acc_if.sv
// Operand/result bundle for the iterative multiply-accumulate block.
// The master side issues start with operands; the slave side returns busy/done/result.
interface seq_mult_acc_if #(
    parameter int W = 8
);
    logic             start;
    logic             signed_mode;
    logic             accumulate;
    logic [W-1:0]     dataa;
    logic [W-1:0]     datab;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;
    logic             overflow;

    modport master (
        output start, signed_mode, accumulate, dataa, datab,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, signed_mode, accumulate, dataa, datab,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/seq_mult_acc.sv
// Iterative shift-add multiplier (unsigned or two's complement) with optional
// accumulate into the 2W-bit result register and a sticky accumulate overflow flag.
//
// state | meaning
// IDLE  | waiting for start; operands latched as magnitudes on acceptance
// CALC  | W shift-add iterations, one per clock
// FIN   | apply sign, write/accumulate result, pulse done
module seq_mult_acc #(
    parameter int W = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    seq_mult_acc_if.slave bus
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     mplier;
    logic [2*W-1:0]   partial;
    logic [CW-1:0]    cnt;
    logic             sign;
    logic             acc_mode;
    logic             sgn_mode;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;
    logic             overflow;

    logic             a_neg;
    logic             b_neg;
    logic [2*W-1:0]   a_ext;
    logic [2*W-1:0]   a_mag;
    logic [W-1:0]     b_mag;
    logic [2*W-1:0]   prod;
    logic [2*W:0]     sum;
    logic             ovf_u;
    logic             ovf_s;

    // Magnitudes are taken in 2W bits for a so that -2^(W-1) stays exact;
    // for b the W-bit negate of -2^(W-1) is 2^(W-1), which is the right unsigned value.
    assign a_neg = bus.signed_mode & bus.dataa[W-1];
    assign b_neg = bus.signed_mode & bus.datab[W-1];
    assign a_ext = {{W{a_neg}}, bus.dataa};
    assign a_mag = a_neg ? -a_ext : a_ext;
    assign b_mag = b_neg ? -bus.datab : bus.datab;

    assign prod  = sign ? -partial : partial;
    assign sum   = {1'b0, result} + {1'b0, prod};
    assign ovf_u = sum[2*W];
    assign ovf_s = (result[2*W-1] == prod[2*W-1]) && (sum[2*W-1] != result[2*W-1]);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            partial  <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            acc_mode <= 1'b0;
            sgn_mode <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand    <= a_mag;
                        mplier   <= b_mag;
                        sign     <= a_neg ^ b_neg;
                        acc_mode <= bus.accumulate;
                        sgn_mode <= bus.signed_mode;
                        partial  <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        partial <= partial + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (acc_mode) begin
                        result   <= sum[2*W-1:0];
                        overflow <= overflow | (sgn_mode ? ovf_s : ovf_u);
                    end else begin
                        result   <= prod;
                        overflow <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.result   = result;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_seq_mult_acc.sv
// Bench for seq_mult_acc: directed corner cases plus randomized ops against an
// arithmetic reference model of product, accumulate and sticky overflow.
module tb_seq_mult_acc;
    localparam int W  = 8;
    localparam int W4 = 4;

    logic Clock;
    logic Resetn;

    int checks = 0;
    int errors = 0;

    longint model_res = 0;
    bit     model_ovf = 0;

    seq_mult_acc_if #(.W(W))  bus8 ();
    seq_mult_acc_if #(.W(W4)) bus4 ();

    seq_mult_acc #(.W(W))  dut8 (.Clock(Clock), .Resetn(Resetn), .bus(bus8));
    seq_mult_acc #(.W(W4)) dut4 (.Clock(Clock), .Resetn(Resetn), .bus(bus4));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: true integer product folded into a 2W-bit accumulator.
    task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit sm, input bit acc);
        longint pa, pb, p, s;
        bit ovf;
        pa = sm ? longint'($signed(a)) : longint'(a);
        pb = sm ? longint'($signed(b)) : longint'(b);
        p  = (pa * pb) & 64'hFFFF;
        if (!acc) begin
            model_res = p;
            model_ovf = 0;
        end else begin
            if (sm) begin
                s   = longint'($signed(model_res[15:0])) + longint'($signed(p[15:0]));
                ovf = (s > 32767) || (s < -32768);
            end else begin
                s   = model_res + p;
                ovf = (s > 65535);
            end
            model_res = s & 64'hFFFF;
            model_ovf = model_ovf | ovf;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit sm, input bit acc, input string tag);
        int lat;
        @(negedge Clock);
        bus8.dataa = a; bus8.datab = b;
        bus8.signed_mode = sm; bus8.accumulate = acc;
        bus8.start = 1'b1;
        @(posedge Clock); #1;
        bus8.start = 1'b0;
        bus8.dataa = W'($urandom);
        bus8.datab = W'($urandom);
        bus8.signed_mode = 1'($urandom);
        bus8.accumulate  = 1'($urandom);
        chk({tag, "_busy0"}, bus8.busy, 1);
        lat = 0;
        while (!bus8.done && lat < 40) begin
            @(posedge Clock); #1;
            lat++;
            if (!bus8.done) chk({tag, "_busy"}, bus8.busy, 1);
        end
        model_op(a, b, sm, acc);
        chk({tag, "_lat"}, lat, W + 1);
        chk({tag, "_busy_end"}, bus8.busy, 0);
        chk({tag, "_res"}, bus8.result, model_res);
        chk({tag, "_ovf"}, bus8.overflow, model_ovf);
        @(posedge Clock); #1;
        chk({tag, "_done_pulse"}, bus8.done, 0);
    endtask

    initial begin
        int n, busy_cnt, dones, first_edge;
        int edges_at[$];

        bus8.start = 0; bus8.signed_mode = 0; bus8.accumulate = 0; bus8.dataa = 0; bus8.datab = 0;
        bus4.start = 0; bus4.signed_mode = 0; bus4.accumulate = 0; bus4.dataa = 0; bus4.datab = 0;
        Resetn = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_busy", bus8.busy, 0);
        chk("rst_done", bus8.done, 0);
        chk("rst_res", bus8.result, 0);
        chk("rst_ovf", bus8.overflow, 0);
        chk("rst_res4", bus4.result, 0);
        @(negedge Clock);
        Resetn = 1'b1;

        // W=4: 15*15, latency and busy window
        @(negedge Clock);
        bus4.dataa = 4'd15; bus4.datab = 4'd15; bus4.start = 1'b1;
        @(posedge Clock); #1;
        bus4.start = 1'b0;
        n = 0; busy_cnt = 0;
        while (!bus4.done && n < 20) begin
            if (bus4.busy) busy_cnt++;
            @(posedge Clock); #1;
            n++;
        end
        chk("w4_lat", n, W4 + 1);
        chk("w4_busy_cycles", busy_cnt, W4 + 1);
        chk("w4_res", bus4.result, 16'h00E1);
        @(posedge Clock); #1;
        chk("w4_done_pulse", bus4.done, 0);

        // Directed W=8 corners
        run_op(8'h80, 8'h80, 1, 0, "s_min_sq");
        chk("s_min_sq_const", bus8.result, 16'h4000);
        chk("s_min_sq_ovf", bus8.overflow, 0);
        run_op(8'hFD, 8'h05, 1, 0, "s_neg");
        chk("s_neg_const", bus8.result, 16'hFFF1);
        run_op(8'd200, 8'd200, 0, 0, "u200");
        chk("u200_const", bus8.result, 16'h9C40);
        run_op(8'd200, 8'd200, 0, 1, "u200_acc");
        chk("u200_acc_const", bus8.result, 16'h3880);
        chk("u200_acc_ovf", bus8.overflow, 1);
        run_op(8'd2, 8'd3, 0, 0, "u2x3");
        chk("u2x3_const", bus8.result, 16'h0006);
        chk("u2x3_ovf", bus8.overflow, 0);

        // start re-pulsed while busy is ignored
        @(negedge Clock);
        bus8.dataa = 8'd1; bus8.datab = 8'd1; bus8.signed_mode = 0; bus8.accumulate = 0;
        bus8.start = 1'b1;
        @(posedge Clock); #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        bus8.dataa = 8'd9; bus8.datab = 8'd9; bus8.start = 1'b1;
        @(posedge Clock); #1;
        bus8.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(posedge Clock); #1;
            if (bus8.done) dones++;
        end
        model_op(8'd1, 8'd1, 0, 0);
        chk("repulse_dones", dones, 1);
        chk("repulse_res", bus8.result, 16'h0001);

        // reset in the middle of CALC aborts the op
        @(negedge Clock);
        bus8.dataa = 8'd255; bus8.datab = 8'd255; bus8.start = 1'b1;
        @(posedge Clock); #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        Resetn = 1'b0;
        #1;
        chk("abort_busy", bus8.busy, 0);
        chk("abort_res", bus8.result, 0);
        model_res = 0; model_ovf = 0;
        @(negedge Clock);
        Resetn = 1'b1;
        dones = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge Clock); #1;
            if (bus8.done) dones++;
        end
        chk("abort_no_done", dones, 0);
        run_op(8'd2, 8'd2, 0, 0, "after_abort");
        chk("after_abort_const", bus8.result, 16'h0004);

        // start held high: one op every W+2 cycles
        @(negedge Clock);
        bus8.dataa = 8'd5; bus8.datab = 8'd7; bus8.signed_mode = 0; bus8.accumulate = 0;
        bus8.start = 1'b1;
        n = 0;
        while (edges_at.size() < 3 && n < 60) begin
            @(posedge Clock); #1;
            n++;
            if (bus8.done) begin
                edges_at.push_back(n);
                chk("held_res", bus8.result, 16'h0023);
            end
        end
        bus8.start = 1'b0;
        chk("held_count", edges_at.size(), 3);
        if (edges_at.size() == 3) begin
            first_edge = edges_at[0];
            chk("held_first", first_edge, W + 2);
            chk("held_gap1", edges_at[1] - edges_at[0], W + 2);
            chk("held_gap2", edges_at[2] - edges_at[1], W + 2);
        end
        model_op(8'd5, 8'd7, 0, 0);
        repeat (W + 3) @(posedge Clock);
        #1;
        chk("held_idle_busy", bus8.busy, 0);

        // randomized ops, accumulate chains included
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0), "rand");
        end
        run_op(8'h7F, 8'h7F, 1, 0, "s_pos_max");
        run_op(8'h7F, 8'h7F, 1, 1, "s_pos_acc");
        run_op(8'h7F, 8'h7F, 1, 1, "s_pos_acc2");
        run_op(8'h00, 8'hFF, 0, 0, "zero");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
